// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns, one 32-bit column per clock.
// A valid/ready handshake sits on each side and the result is held until it is taken.
module mix_columns_seq #(
   parameter int Nb = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          inv,
   input  logic [Nb-1:0] state_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [Nb-1:0] state_out
);
   localparam int unsigned BYTE = 8;
   localparam int unsigned WORD = 32;
   localparam int unsigned NCOL = Nb / WORD;
   localparam int unsigned CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [Nb-1:0]   r_work;
   logic            r_mode;
   logic            r_in_ready;
   logic            r_out_valid;

   logic [WORD-1:0] w_col;
   logic [WORD-1:0] w_x2, w_x4, w_x8;
   logic [WORD-1:0] w_mixed;
   logic [Nb-1:0]   w_work_nx;

   function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [WORD-1:0] xtime4(input logic [WORD-1:0] w);
      logic [WORD-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < 4; k++) r[k*BYTE +: BYTE] = xtime(w[k*BYTE +: BYTE]);
      return r;
   endfunction

   // Rotating the word left by n bytes lines up b_(i+n) with b_i for every row.
   function automatic logic [WORD-1:0] rot(input logic [WORD-1:0] w, input int unsigned n);
      logic [WORD-1:0] r;
      r = w;
      for (int unsigned k = 0; k < n; k++) r = {r[WORD-BYTE-1:0], r[WORD-1:WORD-BYTE]};
      return r;
   endfunction

   always_comb begin
      w_col = '0;
      for (int unsigned c = 0; c < NCOL; c++)
         if (CW'(c) == r_cnt) w_col = r_work[(NCOL-1-c)*WORD +: WORD];
   end

   // Inverse coefficients 0E/0B/0D/09 differ from the forward 02/03/01/01 by
   // 8*(sum of all bytes) ^ 4*b_i ^ 4*b_(i+2), so both modes share the forward core.
   always_comb begin
      w_x2    = xtime4(w_col);
      w_x4    = xtime4(w_x2);
      w_x8    = xtime4(w_x4);
      w_mixed = w_x2 ^ rot(w_x2, 1) ^ rot(w_col, 1) ^ rot(w_col, 2) ^ rot(w_col, 3);
      if (r_mode)
         w_mixed = w_mixed ^ w_x8 ^ rot(w_x8, 1) ^ rot(w_x8, 2) ^ rot(w_x8, 3)
                 ^ w_x4 ^ rot(w_x4, 2);
   end

   always_comb begin
      w_work_nx = r_work;
      for (int unsigned c = 0; c < NCOL; c++)
         if (CW'(c) == r_cnt) w_work_nx[(NCOL-1-c)*WORD +: WORD] = w_mixed;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_work      <= '0;
         r_mode      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work     <= state_in;
                  r_mode     <= inv;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               r_work <= w_work_nx;
               if (r_cnt == LAST) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign state_out = r_work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: fixed vectors, handshake corner cases and random round trips
// on a 128-bit and a 256-bit instance, against a generic GF(2^8) matrix model.
module tb_mix_columns_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_in_valid, a_in_ready, a_inv, a_out_valid, a_out_ready;
   logic [127:0] a_state_in, a_state_out;
   logic         b_in_valid, b_in_ready, b_inv, b_out_valid, b_out_ready;
   logic [255:0] b_state_in, b_state_out;

   int checks   = 0;
   int failures = 0;

   mix_columns_seq #(.Nb(128)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .inv(a_inv), .state_in(a_state_in),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .state_out(a_state_out)
   );

   mix_columns_seq #(.Nb(256)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .inv(b_inv), .state_in(b_state_in),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .state_out(b_state_out)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Carry-less product followed by long division by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011B << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [255:0] ref_mix(input logic [255:0] s, input int ncol, input bit m);
      logic [255:0] r;
      logic [7:0]   b[4];
      logic [7:0]   coef[4];
      logic [7:0]   o;
      r = '0;
      if (m) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
      else   coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < ncol; c++) begin
         for (int i = 0; i < 4; i++) b[i] = s[ncol*32 - 1 - c*32 - i*8 -: 8];
         for (int i = 0; i < 4; i++) begin
            o = '0;
            for (int j = 0; j < 4; j++) o = o ^ gmul(coef[(j - i + 4) % 4], b[j]);
            r[ncol*32 - 1 - c*32 - i*8 -: 8] = o;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic xact_a(input logic [127:0] s, input bit m, input bit tog,
                         output logic [127:0] r, output int lat);
      int n;
      @(negedge clk);
      a_state_in = s; a_inv = m; a_in_valid = 1'b1;
      n = 0;
      while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
      if (!a_in_ready) begin
         chk("a_accept_timeout", 0, 1);
         a_in_valid = 1'b0; r = '0; lat = -1;
         return;
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_state_in = rnd128(); lat = 0;
      while (!a_out_valid && lat < 40) begin
         if (tog) a_inv = ~a_inv;
         @(posedge clk); #1; lat++;
      end
      if (!a_out_valid) chk("a_done_timeout", 0, 1);
      r = a_state_out;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      chk("a_release_out_valid", 256'(a_out_valid), 0);
      chk("a_release_in_ready", 256'(a_in_ready), 1);
   endtask

   task automatic xact_b(input logic [255:0] s, input bit m,
                         output logic [255:0] r, output int lat);
      int n;
      @(negedge clk);
      b_state_in = s; b_inv = m; b_in_valid = 1'b1;
      n = 0;
      while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
      if (!b_in_ready) begin
         chk("b_accept_timeout", 0, 1);
         b_in_valid = 1'b0; r = '0; lat = -1;
         return;
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_state_in = '0; lat = 0;
      while (!b_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      if (!b_out_valid) chk("b_done_timeout", 0, 1);
      r = b_state_out;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      chk("b_release_out_valid", 256'(b_out_valid), 0);
   endtask

   typedef struct {
      string        name;
      logic [127:0] s;
      bit           m;
      logic [127:0] e;
   } vec_t;

   initial begin
      vec_t         tv[5];
      logic [127:0] r, r2, s;
      logic [255:0] rb, rb2, sb, exp_w;
      int           lat, n;

      tv[0] = '{"fips_fwd", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
      tv[1] = '{"fips_inv", 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
                            128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
      tv[2] = '{"zero_fwd", 128'h0, 1'b0, 128'h0};
      tv[3] = '{"ones_inv", 128'h01010101_01010101_01010101_01010101, 1'b1,
                            128'h01010101_01010101_01010101_01010101};
      tv[4] = '{"undo_fwd", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                            128'hdb135345_f20a225c_01010101_c6c6c6c6};

      rst = 1'b1;
      a_in_valid = 1'b0; a_inv = 1'b0; a_out_ready = 1'b0; a_state_in = '0;
      b_in_valid = 1'b0; b_inv = 1'b0; b_out_ready = 1'b0; b_state_in = '0;
      #2;
      chk("reset_out_valid", 256'(a_out_valid), 0);
      chk("reset_in_ready", 256'(a_in_ready), 1);
      chk("reset_state_out", 256'(a_state_out), 0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         xact_a(tv[i].s, tv[i].m, 1'b0, r, lat);
         chk(tv[i].name, 256'(r), 256'(tv[i].e));
         chk({tv[i].name, "_latency"}, 256'(lat), 4);
      end

      // Asynchronous reset in the middle of a transaction
      @(negedge clk);
      a_state_in = tv[0].s; a_inv = 1'b0; a_in_valid = 1'b1;
      @(posedge clk); #1; a_in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midbusy_rst_out_valid", 256'(a_out_valid), 0);
      chk("midbusy_rst_in_ready", 256'(a_in_ready), 1);
      chk("midbusy_rst_state_out", 256'(a_state_out), 0);
      @(negedge clk); rst = 1'b0;
      xact_a(tv[0].s, 1'b0, 1'b0, r, lat);
      chk("after_rst_fwd", 256'(r), 256'(tv[0].e));

      // Back-pressure with a pending new request held on the input
      @(negedge clk);
      a_state_in = tv[0].s; a_inv = 1'b0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_state_in = tv[1].s; a_inv = 1'b1;
      n = 0;
      while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
      chk("bp_reached_done", 256'(a_out_valid), 1);
      for (int k = 0; k < 10; k++) begin
         chk("bp_state_out", 256'(a_state_out), 256'(tv[0].e));
         chk("bp_in_ready", 256'(a_in_ready), 0);
         chk("bp_out_valid", 256'(a_out_valid), 1);
         @(posedge clk); #1;
      end
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0; a_in_valid = 1'b0;
      chk("bp_release_out_valid", 256'(a_out_valid), 0);
      chk("bp_release_in_ready", 256'(a_in_ready), 1);
      chk("bp_idle_holds_result", 256'(a_state_out), 256'(tv[0].e));

      // inv toggles every cycle while busy; the accept-time mode must govern
      xact_a(tv[0].s, 1'b0, 1'b1, r, lat);
      chk("mode_latch_fwd", 256'(r), 256'(tv[0].e));

      for (int i = 0; i < 1000; i++) begin
         s = rnd128();
         xact_a(s, 1'b0, 1'b0, r, lat);
         exp_w = ref_mix(256'(s), 4, 1'b0);
         chk("rand128_fwd", 256'(r), exp_w);
         chk("rand128_latency", 256'(lat), 4);
         xact_a(r, 1'b1, 1'b0, r2, lat);
         chk("rand128_roundtrip", 256'(r2), 256'(s));
      end

      for (int i = 0; i < 300; i++) begin
         sb = {rnd128(), rnd128()};
         xact_b(sb, 1'b0, rb, lat);
         exp_w = ref_mix(sb, 8, 1'b0);
         chk("rand256_fwd", rb, exp_w);
         chk("rand256_latency", 256'(lat), 8);
         xact_b(rb, 1'b1, rb2, lat);
         exp_w = ref_mix(rb, 8, 1'b1);
         chk("rand256_inv", rb2, exp_w);
         chk("rand256_roundtrip", rb2, sb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
